cpu_exec_unit: RTL and testbench
================================

// Module: cpu_exec_unit
// PURPOSE
//  Datapath execution unit of the 16-bit RISC processor, directly downstream of the control unit.
//  It consumes the control word: register addresses, s_sel, rw_en and alu_op.
//  Holds an 8 x 16 register file, a 16-bit ALU and the write-back mux (ALU result or memory data).
//  Returns combinational N/Z/C flags to the control unit, which latches them.
//  Supplies the memory address and store data.
// PARAMETERS
//  DATA_W  16  datapath width; flags are defined on bit DATA_W-1
//  ADDR_W  3   register address width
//  REG_N   8   number of registers (2**ADDR_W)
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       asynchronous, active-high
//  W_Adr    in   3       register file write address
//  R_Adr    in   3       read port R address (ALU operand A / memory address)
//  S_Adr    in   3       read port S address (ALU operand B / store data)
//  s_sel    in   1       write-back select: 0 = ALU result, 1 = DS (memory data)
//  rw_en    in   1       register write enable
//  alu_op   in   4       ALU operation code
//  DS       in   16      data from memory (LD/LDI)
//  Reg_Out  out  16      R[R_Adr], combinational; memory address
//  Alu_Out  out  16      ALU result; equals R[S_Adr] for alu_op 0000 (store data)
//  N,Z,C    out  1 each  ALU flags, combinational
// BEHAVIOUR
//  - Reset: every register is cleared to 16'h0000 asynchronously.
//    Outputs then follow from zeroed registers: Reg_Out=0, Alu_Out=op(0,0), Z=1 for non-flag-setting ops.
//  - Write: on posedge clk with rw_en=1, R[W_Adr] <= s_sel ? DS : Alu_Out. No write when rw_en=0.
//  - R0 is an ordinary register (not hardwired).
//  - Reads: combinational and asynchronous.
//  - Same-cycle read/write of one address: the read returns the OLD value; the new value is visible
//    after the edge. No bypass.
//  - ALU ops (R = R[R_Adr], S = R[S_Adr], 17-bit internal sum for carry):
//     0000 pass S     : Y=S,       C=0
//     0001 pass R     : Y=R,       C=0
//     0010 inc        : Y=S+1,     C=carry out (S=FFFF -> Y=0, C=1)
//     0011 dec        : Y=S-1,     C=borrow (S=0000 -> Y=FFFF, C=1)
//     0100 add        : Y=R+S,     C=carry out of bit 15
//     0101 sub        : Y=R-S,     C=1 if R<S unsigned (borrow)
//     0110 shr        : Y={0,S[15:1]} (logical), C=S[0]
//     0111 shl        : Y={S[14:0],0}, C=S[15]
//     1000 and  1001 or  1010 xor  1011 not S : C=0
//     1100-1111 reserved: Y=S, C=0
//  - Flags: N=Y[15], Z=(Y==0) and C as above.
//    Flags are always driven; the control unit decides when to latch them.
//    With s_sel=1 the flags still reflect the ALU result, not DS.
//  - Latency: each register op completes in one clock; the result is readable the next cycle.
//  - Reset mid-operation: clears the file immediately; a coincident write is discarded.
// TESTING
//  - Reset, then read all 8 addresses -> all 0000; alu_op=0000 -> Z=1, N=0, C=0.
//  - Load R1=7FFF, R2=0001 via s_sel=1 and DS; add W=3,R=1,S=2
//    -> R3=8000 next cycle, N=1, Z=0, C=0.
//  - R4=FFFF: inc W=5,S=4 -> R5=0000, Z=1, C=1; dec of R5 -> FFFF, C=1, N=1.
//  - sub with R=0003, S=0005 -> Y=FFFE, C=1, N=1; CMP-style (rw_en=0) -> no register changes.
//  - R6=8001: shl -> 0002, C=1; shr -> 4000, C=1.
//    Write R6 with R_Adr=6 in the same cycle -> Reg_Out old value until the edge.
//  - Assert reset between edges while rw_en=1 -> all registers 0000; the write never lands.

Source files
------------

// File: rtl/cpu_exec_unit.sv
// cpu_exec_unit: datapath execution unit of the 16-bit RISC processor.
// Holds the register file, the ALU and the write-back mux. Reads, the ALU
// result and the N/Z/C flags are purely combinational; the control unit
// downstream decides when the flags are latched.
module cpu_exec_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int REG_N  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] W_Adr,
    input  logic [ADDR_W-1:0] R_Adr,
    input  logic [ADDR_W-1:0] S_Adr,
    input  logic              s_sel,
    input  logic              rw_en,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] DS,
    output logic [DATA_W-1:0] Reg_Out,
    output logic [DATA_W-1:0] Alu_Out,
    output logic              N,
    output logic              Z,
    output logic              C
);

    typedef enum logic [3:0] {
        OP_PASS_S = 4'b0000,
        OP_PASS_R = 4'b0001,
        OP_INC    = 4'b0010,
        OP_DEC    = 4'b0011,
        OP_ADD    = 4'b0100,
        OP_SUB    = 4'b0101,
        OP_SHR    = 4'b0110,
        OP_SHL    = 4'b0111,
        OP_AND    = 4'b1000,
        OP_OR     = 4'b1001,
        OP_XOR    = 4'b1010,
        OP_NOT    = 4'b1011
    } alu_op_e;

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] s_val;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] wb_data;

    // Asynchronous read ports; a same-cycle write is not bypassed, so a read
    // of the address being written returns the old contents until the edge.
    assign r_val = regs[R_Adr];
    assign s_val = regs[S_Adr];

    // ALU: 17-bit internal sum so carry/borrow fall out of the top bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        alu_y = s_val;
        alu_c = 1'b0;
        sum   = '0;
        case (alu_op)
            OP_PASS_S: alu_y = s_val;
            OP_PASS_R: alu_y = r_val;
            OP_INC: begin
                sum   = {1'b0, s_val} + {{DATA_W{1'b0}}, 1'b1};
                alu_y = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            OP_DEC: begin
                // Bit DATA_W of the 17-bit difference is the borrow.
                sum   = {1'b0, s_val} - {{DATA_W{1'b0}}, 1'b1};
                alu_y = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            OP_ADD: begin
                sum   = {1'b0, r_val} + {1'b0, s_val};
                alu_y = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            OP_SUB: begin
                sum   = {1'b0, r_val} - {1'b0, s_val};
                alu_y = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            OP_SHR: begin
                alu_y = {1'b0, s_val[DATA_W-1:1]};
                alu_c = s_val[0];
            end
            OP_SHL: begin
                alu_y = {s_val[DATA_W-2:0], 1'b0};
                alu_c = s_val[DATA_W-1];
            end
            OP_AND:  alu_y = r_val & s_val;
            OP_OR:   alu_y = r_val | s_val;
            OP_XOR:  alu_y = r_val ^ s_val;
            OP_NOT:  alu_y = ~s_val;
            default: alu_y = s_val;   // reserved codes pass S
        endcase
    end

    // Flags always reflect the ALU result, even when memory data is written back.
    assign Reg_Out = r_val;
    assign Alu_Out = alu_y;
    assign N       = alu_y[DATA_W-1];
    assign Z       = (alu_y == '0);
    assign C       = alu_c;

    assign wb_data = s_sel ? DS : alu_y;

    // Register file write; reset wins over a coincident write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this storage is built from flops, not a RAM macro, so it can
            // and must be cleared on reset; a true RAM could not be reset like this.
            for (int i = 0; i < REG_N; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every
                // flop samples pre-edge values regardless of statement order.
                regs[i] <= '0;
            end
        end else if (rw_en) begin
            regs[W_Adr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Testbench for cpu_exec_unit: directed vectors with hand-computed expected
// outputs pushed into a scoreboard queue; a monitor pops and compares on the
// falling edge, after the inputs have settled and before the write edge.
module tb_cpu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        s_sel, rw_en;
    logic [3:0]  alu_op;
    logic [15:0] DS;
    logic [15:0] Reg_Out, Alu_Out;
    logic        N, Z, C;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] reg_out;
        logic [15:0] alu_out;
        logic        n;
        logic        z;
        logic        c;
    } exp_t;

    exp_t sb_q[$];

    cpu_exec_unit dut (
        .clk     (clk),
        .reset   (reset),
        .W_Adr   (W_Adr),
        .R_Adr   (R_Adr),
        .S_Adr   (S_Adr),
        .s_sel   (s_sel),
        .rw_en   (rw_en),
        .alu_op  (alu_op),
        .DS      (DS),
        .Reg_Out (Reg_Out),
        .Alu_Out (Alu_Out),
        .N       (N),
        .Z       (Z),
        .C       (C)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".reg_out"}, Reg_Out, e.reg_out);
                check({e.name, ".alu_out"}, Alu_Out, e.alu_out);
                check({e.name, ".N"}, {15'h0, N}, {15'h0, e.n});
                check({e.name, ".Z"}, {15'h0, Z}, {15'h0, e.z});
                check({e.name, ".C"}, {15'h0, C}, {15'h0, e.c});
            end
        end
    end

    // Drive one cycle of control word just after the edge and queue its expectation.
    task automatic step(input string name,
                        input logic [2:0] w, input logic [2:0] r, input logic [2:0] s,
                        input logic ssel, input logic rw, input logic [3:0] op,
                        input logic [15:0] ds,
                        input logic [15:0] e_reg, input logic [15:0] e_alu,
                        input logic e_n, input logic e_z, input logic e_c);
        exp_t e;
        @(posedge clk);
        #1;
        W_Adr = w; R_Adr = r; S_Adr = s;
        s_sel = ssel; rw_en = rw; alu_op = op; DS = ds;
        e.name = name; e.reg_out = e_reg; e.alu_out = e_alu;
        e.n = e_n; e.z = e_z; e.c = e_c;
        sb_q.push_back(e);
    endtask

    // Read register k on both ports with pass-S, no write.
    task automatic rd(input int k, input logic [15:0] v);
        logic [2:0] a;
        a = k[2:0];
        step($sformatf("rd%0d", k), 3'd0, a, a, 1'b0, 1'b0, 4'h0, 16'h0,
             v, v, v[15], (v == 16'h0), 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        W_Adr = '0; R_Adr = '0; S_Adr = '0;
        s_sel = 1'b0; rw_en = 1'b0; alu_op = '0; DS = '0;
        #17 reset = 1'b0;

        // Reset state
        for (int k = 0; k < 8; k++) rd(k, 16'h0000);

        //        name      W     R     S     ssel  rw    op     DS        Reg_Out   Alu_Out   N     Z     C
        step("ld_r1",   3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 4'h0, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step("ld_r2",   3'd2, 3'd1, 3'd1, 1'b1, 1'b1, 4'h0, 16'h0001, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        step("add",     3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 4'h4, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0);
        step("ld_r4",   3'd4, 3'd3, 3'd3, 1'b1, 1'b1, 4'h0, 16'hFFFF, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        step("inc",     3'd5, 3'd4, 3'd4, 1'b0, 1'b1, 4'h2, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1);
        step("dec",     3'd7, 3'd5, 3'd5, 1'b0, 1'b1, 4'h3, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        step("ld_r6",   3'd6, 3'd7, 3'd7, 1'b1, 1'b1, 4'h0, 16'h0003, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step("ld_r7",   3'd7, 3'd6, 3'd6, 1'b1, 1'b1, 4'h0, 16'h0005, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
        step("cmp",     3'd6, 3'd6, 3'd7, 1'b0, 1'b0, 4'h5, 16'h0000, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        rd(6, 16'h0003);
        rd(7, 16'h0005);
        step("add_cy",  3'd0, 3'd4, 3'd7, 1'b0, 1'b0, 4'h4, 16'h0000, 16'hFFFF, 16'h0004, 1'b0, 1'b0, 1'b1);
        // Same-cycle write/read of R6: read still returns the old value
        step("wr_rd6",  3'd6, 3'd6, 3'd6, 1'b1, 1'b1, 4'h0, 16'h8001, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
        step("shl",     3'd0, 3'd6, 3'd6, 1'b0, 1'b0, 4'h7, 16'h0000, 16'h8001, 16'h0002, 1'b0, 1'b0, 1'b1);
        step("shr",     3'd0, 3'd6, 3'd6, 1'b0, 1'b0, 4'h6, 16'h0000, 16'h8001, 16'h4000, 1'b0, 1'b0, 1'b1);
        step("and",     3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'h8, 16'h0000, 16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0);
        step("or",      3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'h9, 16'h0000, 16'h8001, 16'h8005, 1'b1, 1'b0, 1'b0);
        step("xor",     3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'hA, 16'h0000, 16'h8001, 16'h8004, 1'b1, 1'b0, 1'b0);
        step("not",     3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'hB, 16'h0000, 16'h8001, 16'hFFFA, 1'b1, 1'b0, 1'b0);
        step("resv",    3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'hC, 16'h0000, 16'h8001, 16'h0005, 1'b0, 1'b0, 1'b0);
        step("pass_r",  3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'h1, 16'h0000, 16'h8001, 16'h8001, 1'b1, 1'b0, 1'b0);
        step("sub_nb",  3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'h5, 16'h0000, 16'h8001, 16'h7FFC, 1'b0, 1'b0, 1'b0);
        step("dec_nb",  3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 4'h3, 16'h0000, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0);
        step("inc_nb",  3'd0, 3'd6, 3'd6, 1'b0, 1'b0, 4'h2, 16'h0000, 16'h8001, 16'h8002, 1'b1, 1'b0, 1'b0);
        // Flags follow the ALU, not DS, on a memory load
        step("ld_flag", 3'd0, 3'd5, 3'd5, 1'b1, 1'b1, 4'h0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        rd(0, 16'h8000);

        // Reset between edges while a write of R1 is pending
        step("pre_rst", 3'd1, 3'd1, 3'd1, 1'b1, 1'b1, 4'h0, 16'h1234, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rw_en = 1'b0;
        for (int k = 0; k < 8; k++) rd(k, 16'h0000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
